// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: FSM state encoding,
// load/store direction codes and a small address helper.
package mem_pkg;

  // State encoding of the access FSM
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Direction of a RAM access (ram_rw_i / rw_q)
  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_DONE = ST_DONE
  } state_e;

  // Word accesses must have the two low address bits clear
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/acknowledge data bus between the memory access stage (master)
// and the data memory or interconnect (slave).
interface mem_access_if;

  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic        bus_err_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o,
    output bus_we_o,
    output bus_addr_o,
    output bus_wdata_o,
    input  bus_ack_i,
    input  bus_err_i,
    input  bus_rdata_i
  );

  modport slave (
    input  bus_req_o,
    input  bus_we_o,
    input  bus_addr_o,
    input  bus_wdata_o,
    output bus_ack_i,
    output bus_err_i,
    output bus_rdata_i
  );

endinterface

// File: rtl/mem_wdt.sv
// Bus-transaction watchdog: counts cycles while enabled and flags the last
// allowed cycle. TIMEOUT_CYC = 0 disables expiry altogether.
module mem_wdt #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // Cycle counter: cleared on reset or clr, advances while en is high
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_wdt_off
      assign expire = 1'b0;
    end else begin : g_wdt_on
      localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);
      assign expire = en & (cnt == LAST_CNT);
    end
  endgenerate

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage. Turns the execute stage's RAM request into one
// req/ack bus transaction, stalls the pipeline while it is outstanding and
// returns load data with its register write-back. Bus errors and watchdog
// timeouts are reported on err_o.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned word
// addresses without touching the bus.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en_i,
  input  logic        ram_rw_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        wen_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        regs_wen_o,
  output logic [4:0]  regs_rd_o,
  output logic [31:0] regs_rd_data_o,
  mem_access_if.master bus
);

  state_e      state;
  state_e      state_nx;

  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        rw_q;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        misalign;
  logic        wdt_expire;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_misaligned(ram_addr_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Watchdog restarts in every IDLE cycle and counts only REQ cycles
  mem_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == S_IDLE),
    .en     (state == S_REQ),
    .expire (wdt_expire)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; an ack in the final watchdog cycle still completes normally
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (ram_en_i) begin
          if (misalign) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_REQ;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.bus_ack_i) begin
          state_nx = S_DONE;
        end else if (wdt_expire) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_REQ;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Request capture in IDLE and response capture in REQ
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      rw_q    <= RW_LOAD;
      rd_q    <= 5'd0;
      wen_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ram_en_i) begin
            addr_q <= ram_addr_i;
            data_q <= ram_data_i;
            rw_q   <= ram_rw_i;
            rd_q   <= rd_addr_i;
            wen_q  <= wen_i;
            err_q  <= misalign;
          end
        end
        S_REQ: begin
          if (bus.bus_ack_i) begin
            err_q <= bus.bus_err_i;
            if (!bus.bus_err_i) begin
              rdata_q <= bus.bus_rdata_i;
            end
          end else if (wdt_expire) begin
            err_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: everything idles at zero except in the state that owns it
  always_comb begin
    stall_o         = 1'b0;
    done_o          = 1'b0;
    err_o           = 1'b0;
    regs_wen_o      = 1'b0;
    regs_rd_o       = 5'd0;
    regs_rd_data_o  = 32'h0000_0000;
    bus.bus_req_o   = 1'b0;
    bus.bus_we_o    = 1'b0;
    bus.bus_addr_o  = 32'h0000_0000;
    bus.bus_wdata_o = 32'h0000_0000;
    case (state)
      S_IDLE: begin
        stall_o = ram_en_i;
      end
      S_REQ: begin
        stall_o         = 1'b1;
        bus.bus_req_o   = 1'b1;
        bus.bus_we_o    = rw_q;
        bus.bus_addr_o  = addr_q;
        bus.bus_wdata_o = data_q;
      end
      S_DONE: begin
        if (err_q) begin
          err_o = 1'b1;
        end else begin
          done_o = 1'b1;
          if (rw_q == RW_LOAD) begin
            regs_wen_o     = wen_q;
            regs_rd_o      = rd_q;
            regs_rd_data_o = rdata_q;
          end else begin
            regs_wen_o = 1'b0;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule
